// File: rtl/s1488_campaign_pkg.sv
// Shared types and constants for the s1488 cone fault-injection campaign controller.
package s1488_campaign_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } state_e;

    // Feedback taps x^16 + x^14 + x^13 + x^11 + 1 as a bit mask (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    // The all-zero state is a lock-up state for an XOR LFSR.
    function automatic logic [15:0] seed_guard(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/s1488_lfsr16.sv
// 16-bit Fibonacci stimulus LFSR with load, advance and zero-seed guard.
module s1488_lfsr16
    import s1488_campaign_pkg::*;
#(
    parameter int OUT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      seed,
    input  logic             advance,
    output logic [OUT_W-1:0] next_low
);

    logic [15:0] lfsr_r;
    logic [15:0] seed_s;
    logic [15:0] next_s;

    // guarded seed and single-step successor of the current state
    always_comb begin
        seed_s = seed_guard(seed);
        next_s = lfsr_step(lfsr_r);
    end

    // shift register; a load takes priority over an advance
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= seed_s;
        end else if (load) begin
            lfsr_r <= seed_s;
        end else if (advance) begin
            lfsr_r <= next_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign next_low = next_s[OUT_W-1:0];

endmodule

// File: rtl/s1488_cone_campaign_ctrl.sv
// Fault-injection campaign sequencer for a golden/faulty s1488 cone pair.
// Optional S1488_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module s1488_cone_campaign_ctrl
    import s1488_campaign_pkg::*;
#(
    parameter int          VEC_W  = 14,
    parameter int          CNT_W  = 16,
    parameter int          SETTLE = 2,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             golden_in,
    input  logic             faulty_in,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_valid
);

    localparam int               SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_ZERO = {SET_W{1'b0}};
    localparam logic [SET_W-1:0] SET_ONE  = {{(SET_W-1){1'b0}}, 1'b1};
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [VEC_W-1:0] VEC_ZERO = {VEC_W{1'b0}};
    localparam logic [15:0]      SEED_EFF = seed_guard(SEED);

    state_e           state_r;
    logic [SET_W-1:0] settle_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] mismatch_r;
    logic [CNT_W-1:0] ff_idx_r;
    logic             ff_valid_r;
    logic             busy_r;
    logic             done_r;
    logic [VEC_W-1:0] vec_r;

    logic             accept_s;
    logic             sample_s;
    logic             miss_s;
    logic             last_s;
    logic             stop_s;
    logic [CNT_W-1:0] idx_inc_s;
    logic [CNT_W-1:0] mismatch_inc_s;
    logic [VEC_W-1:0] lfsr_next_s;

    s1488_lfsr16 #(
        .OUT_W (VEC_W)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .seed     (SEED),
        .advance  (sample_s),
        .next_low (lfsr_next_s)
    );

    // per-state strobes, saturating increment and end-of-run decision
    always_comb begin
        accept_s = 1'b0;
        sample_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_FIN: accept_s = start;
            ST_HOLD:         sample_s = 1'b0;
            ST_SAMPLE:       sample_s = 1'b1;
            default: begin
                accept_s = 1'b0;
                sample_s = 1'b0;
            end
        endcase
        miss_s    = golden_in ^ faulty_in;
        idx_inc_s = idx_r + CNT_ONE;
        last_s    = (idx_inc_s == count_r);
        if (mismatch_r == CNT_MAX) begin
            mismatch_inc_s = mismatch_r;
        end else begin
            mismatch_inc_s = mismatch_r + CNT_ONE;
        end
`ifdef S1488_STOP_ON_FAIL_EN
        stop_s = miss_s;
`else
        stop_s = 1'b0;
`endif
    end

    // campaign sequencer: state, settle timer, vector index and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            settle_r   <= SET_ZERO;
            count_r    <= CNT_ZERO;
            idx_r      <= CNT_ZERO;
            mismatch_r <= CNT_ZERO;
            ff_idx_r   <= CNT_ZERO;
            ff_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            vec_r      <= VEC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_FIN: begin
                    if (accept_s) begin
                        count_r    <= num_vectors;
                        settle_r   <= SET_ZERO;
                        idx_r      <= CNT_ZERO;
                        mismatch_r <= CNT_ZERO;
                        ff_idx_r   <= CNT_ZERO;
                        ff_valid_r <= 1'b0;
                        if (num_vectors == CNT_ZERO) begin
                            state_r <= ST_FIN;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_HOLD;
                            vec_r   <= SEED_EFF[VEC_W-1:0];
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (settle_r == SET_LAST) begin
                        settle_r <= SET_ZERO;
                        state_r  <= ST_SAMPLE;
                    end else begin
                        settle_r <= settle_r + SET_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (miss_s) begin
                        mismatch_r <= mismatch_inc_s;
                        if (!ff_valid_r) begin
                            ff_idx_r   <= idx_r;
                            ff_valid_r <= 1'b1;
                        end
                    end
                    idx_r <= idx_inc_s;
                    // vec_out keeps the last applied vector once the run ends
                    if (last_s || stop_s) begin
                        state_r <= ST_FIN;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_HOLD;
                        vec_r   <= lfsr_next_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_out          = vec_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign mismatch_cnt     = mismatch_r;
    assign first_fail_idx   = ff_idx_r;
    assign first_fail_valid = ff_valid_r;

endmodule

// File: doc/s1488_cone_campaign_ctrl.md
# s1488_cone_campaign_ctrl

Sequencer for fault-injection campaigns on s1488 partial-output cones. It drives one pseudo-random 14-bit stimulus vector at a time into a golden cone instance and a fault-injected cone instance in parallel. After a programmable settle time it compares their single-bit responses and accumulates mismatch statistics. It sits between the campaign testbench/host and the pair of combinational cone netlists.

## Interface
- `VEC_W`, default 14: cone input width. Bit order is {v0..v12, CLR}, with bit 0 = CLR.
- `CNT_W`, default 16: width of the vector count and all counters.
- `SETTLE`, default 2: hold cycles before sampling. Must be ≥1.
- `SEED`, default 16'hACE1: LFSR seed. A seed of 0 is replaced by 16'h0001.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: run request. Sampled only in IDLE or FIN.
- `num_vectors` input CNT_W: vectors to apply. Latched on accepted `start`.
- `golden_in` input 1: golden cone response.
- `faulty_in` input 1: fault-injected cone response.
- `vec_out` output VEC_W: stimulus to both cones.
- `busy` output 1: high in HOLD and SAMPLE.
- `done` output 1: high in FIN.
- `mismatch_cnt` output CNT_W: mismatches in the current or last run. Saturating.
- `first_fail_idx` output CNT_W: index of the first mismatching vector, 0-based.
- `first_fail_valid` output 1: `first_fail_idx` is meaningful.

## Operation
- States: IDLE, HOLD, SAMPLE, FIN.
- IDLE/FIN with `start`=1:
  - Latch `num_vectors`, clear counters/flags, load LFSR with SEED.
  - Go to HOLD, or directly to FIN if `num_vectors`=0.
- HOLD: `vec_out` = lfsr[VEC_W-1:0], held stable. A settle counter runs 0..SETTLE-1, then → SAMPLE.
- SAMPLE:
  - Compare `golden_in` ^ `faulty_in`. On mismatch, increment `mismatch_cnt`, saturating at all-ones.
  - If `first_fail_valid`=0, capture the current vector index into `first_fail_idx` and set `first_fail_valid`.
  - Advance the LFSR and the index.
  - If index+1 == latched count → FIN, else → HOLD.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift toward MSB, feedback into bit 0. Never reaches 0.
- FIN: results hold until the next accepted `start` or `rst`. `vec_out` holds the last applied vector.
- `start` while busy: ignored. It has no effect on state or counters.
- `num_vectors` changing mid-run: ignored, because the count was latched at start.

## Timing
- Reset values: state IDLE, `vec_out`=0, `busy`=0, `done`=0, `mismatch_cnt`=0, `first_fail_idx`=0, `first_fail_valid`=0. LFSR=SEED.
- `rst` mid-run: next cycle is IDLE with all reset values. A partial run leaves no residue.
- `start` at edge t: `busy`=1 and `vec_out`=first vector from cycle t+1.
- Each vector is held SETTLE+1 cycles. Responses are sampled on the last of them, the SAMPLE cycle, and cones must settle within SETTLE cycles.
- `mismatch_cnt` and `first_fail_*` update at the edge ending SAMPLE.
- N vectors: `done` rises N·(SETTLE+1) cycles after the `start` edge. `busy` and `done` are never high together.
- `start` in FIN: `done` drops the next cycle and the new run begins.
- `num_vectors`=0: `done`=1 at t+1, counters 0.

## Configuration
- `S1488_STOP_ON_FAIL_EN` defined: the first mismatch in SAMPLE goes to FIN immediately, regardless of the remaining count. `mismatch_cnt`=1 and `first_fail_valid`=1.
- Undefined: all `num_vectors` are always applied.

## Structure
- Package `s1488_campaign_pkg`: state enum, LFSR tap constant, default seed constant.
- One sub-module, `s1488_lfsr16`, with load/seed/advance and zero-seed guard. The FSM, settle counter, index and statistics stay in the top module.

## Test plan
- Reset check: `rst` for 2 cycles → all outputs at reset values. Then `start`, `num_vectors`=4, SETTLE=2, `faulty_in` tied to `golden_in`:
  - `done` rises exactly 12 cycles after `start`.
  - `mismatch_cnt`=0, `first_fail_valid`=0.
  - `vec_out` sequence = SEED[13:0], then the next 3 LFSR states.
- Fault inject: `faulty_in` inverted only during vector index 5 of 10 → `mismatch_cnt`=1, `first_fail_idx`=5, `first_fail_valid`=1.
- Zero vectors: `start` with `num_vectors`=0 → `done`=1 at t+1, `busy` never asserts.
- Saturation: CNT_W=4, always mismatch, `num_vectors`=15, then a second run with 15 → `mismatch_cnt`=15. It is cleared at the second start and never wraps to 0.
- Reset mid-run at vector 3 of 8, then restart with 8 → identical `vec_out` sequence and results to a clean run. Also, `start` pulsed while busy changes nothing.
- With `S1488_STOP_ON_FAIL_EN`: mismatch at index 2 of 10 → FIN after 3·(SETTLE+1) cycles, `mismatch_cnt`=1, `first_fail_idx`=2.
